dshot_frame_rx: RTL and testbench



---
 rtl/dshot_frame_rx.sv | 176 +++++++++++++++++
 tb/tb_dshot_frame_rx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dshot_frame_rx.sv
`default_nettype none
//==============================================================================
// Module : dshot_frame_rx
// Brief  : DShot frame receiver. Decodes pulses, assembles 16-bit frames,
//          maps the throttle to an 8-bit speed and applies a failsafe timeout.
//          Define DSHOT_CRC_CHECK_EN to enable the frame CRC check.
// Rev    : 1.0  initial release
//==============================================================================
module dshot_frame_rx #(
   parameter int BIT_THRESH     = 60,
   parameter int MAX_HIGH       = 150,
   parameter int GAP_CYCLES     = 200,
   parameter int TIMEOUT_CYCLES = 320000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dshotPin,
   output logic [7:0]  outputSpeed,
   output logic [10:0] throttle,
   output logic        telemetry,
   output logic        frame_valid,
   output logic        crc_err,
   output logic        timed_out
);

   localparam int CW = 16;
   localparam int TW = 19;
   localparam logic [CW-1:0] c_bit_thresh = CW'(BIT_THRESH);
   localparam logic [CW-1:0] c_max_high   = CW'(MAX_HIGH);
   localparam logic [CW-1:0] c_gap        = CW'(GAP_CYCLES);
   localparam logic [TW-1:0] c_timeout    = TW'(TIMEOUT_CYCLES);
`ifdef DSHOT_CRC_CHECK_EN
   localparam logic c_crc_en = 1'b1;
`else
   localparam logic c_crc_en = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_READY, S_HIGH, S_LOW, S_CHECK} state_t;
   state_t r_state, w_state_next;

   logic          r_sync1, r_sync2, r_prev;
   logic          w_rise, w_fall;
   logic [CW-1:0] r_idle_cnt, r_hi_cnt, r_lo_cnt;
   logic [CW-1:0] w_idle_inc, w_hi_inc, w_lo_inc;
   logic [4:0]    r_bit_cnt;
   logic [15:0]   r_frame;
   logic [TW-1:0] r_to_cnt, w_to_next;
   logic          w_shift, w_accept, w_reject, w_crc_ok;
   logic [11:0]   w_v;
   logic [3:0]    w_crc_exp;
   logic [10:0]   w_thr_off;
   logic [7:0]    w_speed;

   assign w_rise     = r_sync2 & ~r_prev;
   assign w_fall     = ~r_sync2 & r_prev;
   assign w_idle_inc = r_idle_cnt + CW'(1);
   assign w_hi_inc   = r_hi_cnt + CW'(1);
   assign w_lo_inc   = r_lo_cnt + CW'(1);
   assign w_to_next  = (r_to_cnt == '1) ? r_to_cnt : r_to_cnt + TW'(1);

   assign w_v       = r_frame[15:4];
   assign w_crc_exp = w_v[3:0] ^ w_v[7:4] ^ w_v[11:8];
   assign w_crc_ok  = !c_crc_en || (w_crc_exp == r_frame[3:0]);
   assign w_thr_off = w_v[11:1] - 11'd48;
   assign w_speed   = (w_v[11:1] < 11'd48) ? 8'd0 : 8'(w_thr_off >> 3);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= dshotPin;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Over-long high takes priority over a fall in the same cycle.
   always_comb begin
      w_state_next = r_state;
      w_shift      = 1'b0;
      w_accept     = 1'b0;
      w_reject     = 1'b0;
      case (r_state)
         S_IDLE:  if (!r_sync2 && w_idle_inc >= c_gap) w_state_next = S_READY;
         S_READY: if (w_rise) w_state_next = S_HIGH;
         S_HIGH: begin
            if (w_hi_inc > c_max_high) begin
               w_state_next = S_IDLE;
            end else if (w_fall) begin
               w_shift      = 1'b1;
               w_state_next = (r_bit_cnt == 5'd15) ? S_CHECK : S_LOW;
            end
         end
         S_LOW: begin
            if (w_rise)                  w_state_next = S_HIGH;
            else if (w_lo_inc >= c_gap)  w_state_next = S_READY;
         end
         S_CHECK: begin
            w_state_next = S_IDLE;
            w_accept     = w_crc_ok;
            w_reject     = ~w_crc_ok;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_idle_cnt <= '0;
         r_hi_cnt   <= '0;
         r_lo_cnt   <= '0;
         r_bit_cnt  <= '0;
         r_frame    <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_CHECK: r_idle_cnt <= r_sync2 ? '0 : w_idle_inc;
            S_READY: begin
               r_hi_cnt  <= '0;
               r_bit_cnt <= '0;
            end
            S_HIGH: begin
               r_hi_cnt   <= w_hi_inc;
               // The fall cycle itself already counts toward the inter-frame gap.
               r_idle_cnt <= w_shift ? CW'(1) : '0;
               if (w_shift) begin
                  r_frame   <= {r_frame[14:0], (w_hi_inc >= c_bit_thresh)};
                  r_bit_cnt <= r_bit_cnt + 5'd1;
                  r_lo_cnt  <= '0;
               end
            end
            S_LOW: begin
               r_lo_cnt <= w_lo_inc;
               if (w_rise) r_hi_cnt <= '0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         outputSpeed <= '0;
         throttle    <= '0;
         telemetry   <= 1'b0;
         frame_valid <= 1'b0;
         crc_err     <= 1'b0;
         timed_out   <= 1'b0;
         r_to_cnt    <= '0;
      end else begin
         frame_valid <= w_accept;
         crc_err     <= w_reject;
         if (w_accept) begin
            throttle    <= w_v[11:1];
            telemetry   <= w_v[0];
            outputSpeed <= w_speed;
            r_to_cnt    <= '0;
            timed_out   <= 1'b0;
         end else begin
            r_to_cnt <= w_to_next;
            if (w_to_next >= c_timeout) begin
               timed_out   <= 1'b1;
               outputSpeed <= '0;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dshot_frame_rx.sv
`default_nettype none
//==============================================================================
// Module : tb_dshot_frame_rx
// Brief  : Directed self-checking bench for dshot_frame_rx.
// Rev    : 1.0  initial release
//==============================================================================
module tb_dshot_frame_rx;

   localparam int c_timeout = 8000;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        dshotPin = 1'b0;
   logic [7:0]  outputSpeed;
   logic [10:0] throttle;
   logic        telemetry, frame_valid, crc_err, timed_out;

   int n_cmp = 0, n_err = 0;
   int n_fv = 0, n_ce = 0, n_overlap = 0;
   int cyc = 0, fv_cyc = 0, fall_cyc = 0;
   int pfv, pce;

   dshot_frame_rx #(
      .BIT_THRESH     (60),
      .MAX_HIGH       (150),
      .GAP_CYCLES     (200),
      .TIMEOUT_CYCLES (c_timeout)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .dshotPin    (dshotPin),
      .outputSpeed (outputSpeed),
      .throttle    (throttle),
      .telemetry   (telemetry),
      .frame_valid (frame_valid),
      .crc_err     (crc_err),
      .timed_out   (timed_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_valid) begin
         n_fv   = n_fv + 1;
         fv_cyc = cyc;
      end
      if (crc_err) n_ce = n_ce + 1;
      if (frame_valid && crc_err) n_overlap = n_overlap + 1;
   end

   // Sends the top nbits of f after gap low cycles; 1 = hi1 high/27 low, 0 = hi0 high/67 low.
   task automatic send_frame(input logic [15:0] f, input int nbits, input int gap,
                             input int hi1, input int hi0);
      logic [15:0] d;
      d = f;
      dshotPin = 1'b0;
      repeat (gap) @(negedge clk);
      for (int i = 15; i > 15 - nbits; i--) begin
         dshotPin = 1'b1;
         repeat (d[i] ? hi1 : hi0) @(negedge clk);
         dshotPin = 1'b0;
         fall_cyc = cyc;
         repeat (d[i] ? 27 : 67) @(negedge clk);
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic mark();
      pfv = n_fv;
      pce = n_ce;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (outputSpeed !== 8'd0) begin n_err++; $display("FAIL reset_speed: got %0d expected 0", outputSpeed); end
      n_cmp++; if (throttle !== 11'd0) begin n_err++; $display("FAIL reset_throttle: got %0d expected 0", throttle); end
      n_cmp++; if (telemetry !== 1'b0) begin n_err++; $display("FAIL reset_telem: got %b expected 0", telemetry); end
      n_cmp++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL reset_fv: got %b expected 0", frame_valid); end
      n_cmp++; if (crc_err !== 1'b0) begin n_err++; $display("FAIL reset_crc: got %b expected 0", crc_err); end
      n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL reset_to: got %b expected 0", timed_out); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      mark();
      send_frame(16'h830B, 16, 250, 80, 40);
      n_cmp++; if (n_fv - pfv !== 1) begin n_err++; $display("FAIL basic_fv_count: got %0d expected 1", n_fv - pfv); end
      n_cmp++; if (n_ce - pce !== 0) begin n_err++; $display("FAIL basic_ce_count: got %0d expected 0", n_ce - pce); end
      n_cmp++; if (throttle !== 11'd1048) begin n_err++; $display("FAIL basic_throttle: got %0d expected 1048", throttle); end
      n_cmp++; if (telemetry !== 1'b0) begin n_err++; $display("FAIL basic_telem: got %b expected 0", telemetry); end
      n_cmp++; if (outputSpeed !== 8'd125) begin n_err++; $display("FAIL basic_speed: got %0d expected 125", outputSpeed); end
      n_cmp++; if (fv_cyc - fall_cyc !== 4) begin n_err++; $display("FAIL basic_latency: got %0d expected 4", fv_cyc - fall_cyc); end
   endtask

   task automatic test_full_scale();
      send_frame(16'hFFFF, 16, 250, 80, 40);
      n_cmp++; if (throttle !== 11'd2047) begin n_err++; $display("FAIL full_throttle: got %0d expected 2047", throttle); end
      n_cmp++; if (telemetry !== 1'b1) begin n_err++; $display("FAIL full_telem: got %b expected 1", telemetry); end
      n_cmp++; if (outputSpeed !== 8'd249) begin n_err++; $display("FAIL full_speed: got %0d expected 249", outputSpeed); end
      send_frame(16'h0000, 16, 250, 80, 40);
      n_cmp++; if (throttle !== 11'd0) begin n_err++; $display("FAIL zero_throttle: got %0d expected 0", throttle); end
      n_cmp++; if (telemetry !== 1'b0) begin n_err++; $display("FAIL zero_telem: got %b expected 0", telemetry); end
      n_cmp++; if (outputSpeed !== 8'd0) begin n_err++; $display("FAIL zero_speed: got %0d expected 0", outputSpeed); end
   endtask

   task automatic test_crc();
      send_frame(16'hFFFF, 16, 250, 80, 40);
      mark();
      send_frame(16'h830A, 16, 250, 80, 40);
`ifdef DSHOT_CRC_CHECK_EN
      n_cmp++; if (n_ce - pce !== 1) begin n_err++; $display("FAIL crc_ce_count: got %0d expected 1", n_ce - pce); end
      n_cmp++; if (n_fv - pfv !== 0) begin n_err++; $display("FAIL crc_fv_count: got %0d expected 0", n_fv - pfv); end
      n_cmp++; if (throttle !== 11'd2047) begin n_err++; $display("FAIL crc_throttle_hold: got %0d expected 2047", throttle); end
      n_cmp++; if (outputSpeed !== 8'd249) begin n_err++; $display("FAIL crc_speed_hold: got %0d expected 249", outputSpeed); end
`else
      n_cmp++; if (n_ce - pce !== 0) begin n_err++; $display("FAIL crc_ce_count: got %0d expected 0", n_ce - pce); end
      n_cmp++; if (n_fv - pfv !== 1) begin n_err++; $display("FAIL crc_fv_count: got %0d expected 1", n_fv - pfv); end
      n_cmp++; if (throttle !== 11'd1048) begin n_err++; $display("FAIL crc_throttle: got %0d expected 1048", throttle); end
      n_cmp++; if (outputSpeed !== 8'd125) begin n_err++; $display("FAIL crc_speed: got %0d expected 125", outputSpeed); end
`endif
   endtask

   task automatic test_truncated();
      send_frame(16'h0000, 16, 250, 80, 40);
      mark();
      send_frame(16'h830B, 10, 250, 80, 40);
      repeat (300) @(negedge clk);
      n_cmp++; if (n_fv - pfv !== 0) begin n_err++; $display("FAIL trunc_fv: got %0d expected 0", n_fv - pfv); end
      n_cmp++; if (n_ce - pce !== 0) begin n_err++; $display("FAIL trunc_ce: got %0d expected 0", n_ce - pce); end
      mark();
      send_frame(16'h830B, 16, 0, 80, 40);
      n_cmp++; if (n_fv - pfv !== 1) begin n_err++; $display("FAIL trunc_next_fv: got %0d expected 1", n_fv - pfv); end
      n_cmp++; if (throttle !== 11'd1048) begin n_err++; $display("FAIL trunc_next_throttle: got %0d expected 1048", throttle); end
   endtask

   task automatic test_long_high();
      send_frame(16'h0000, 16, 250, 80, 40);
      mark();
      send_frame(16'h830B, 5, 250, 80, 40);
      dshotPin = 1'b1;
      repeat (200) @(negedge clk);
      dshotPin = 1'b0;
      repeat (10) @(negedge clk);
      n_cmp++; if (n_fv - pfv + n_ce - pce !== 0) begin n_err++; $display("FAIL longhigh_pulses: got %0d expected 0", n_fv - pfv + n_ce - pce); end
      mark();
      send_frame(16'h830B, 16, 250, 80, 40);
      n_cmp++; if (n_fv - pfv !== 1) begin n_err++; $display("FAIL longhigh_next_fv: got %0d expected 1", n_fv - pfv); end
      n_cmp++; if (throttle !== 11'd1048) begin n_err++; $display("FAIL longhigh_throttle: got %0d expected 1048", throttle); end
   endtask

   task automatic test_boundaries();
      send_frame(16'h0000, 16, 250, 80, 40);
      mark();
      send_frame(16'h830B, 16, 250, 60, 59);
      n_cmp++; if (n_fv - pfv !== 1) begin n_err++; $display("FAIL thresh_fv: got %0d expected 1", n_fv - pfv); end
      n_cmp++; if (throttle !== 11'd1048) begin n_err++; $display("FAIL thresh_throttle: got %0d expected 1048", throttle); end
      send_frame(16'hFFFF, 16, 250, 150, 40);
      n_cmp++; if (throttle !== 11'd2047) begin n_err++; $display("FAIL maxhigh_throttle: got %0d expected 2047", throttle); end
      send_frame(16'h0000, 16, 250, 80, 40);
      mark();
      send_frame(16'hFFFF, 16, 250, 151, 40);
      n_cmp++; if (n_fv - pfv !== 0) begin n_err++; $display("FAIL overhigh_fv: got %0d expected 0", n_fv - pfv); end
      n_cmp++; if (throttle !== 11'd0) begin n_err++; $display("FAIL overhigh_throttle: got %0d expected 0", throttle); end
   endtask

   task automatic test_timeout();
      send_frame(16'h830B, 16, 250, 80, 40);
      n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL to_early: got %b expected 0", timed_out); end
      repeat (c_timeout + 20) @(negedge clk);
      n_cmp++; if (timed_out !== 1'b1) begin n_err++; $display("FAIL to_flag: got %b expected 1", timed_out); end
      n_cmp++; if (outputSpeed !== 8'd0) begin n_err++; $display("FAIL to_speed: got %0d expected 0", outputSpeed); end
      n_cmp++; if (throttle !== 11'd1048) begin n_err++; $display("FAIL to_throttle_hold: got %0d expected 1048", throttle); end
      send_frame(16'hFFFF, 16, 250, 80, 40);
      n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL to_clear: got %b expected 0", timed_out); end
      n_cmp++; if (outputSpeed !== 8'd249) begin n_err++; $display("FAIL to_recover_speed: got %0d expected 249", outputSpeed); end
   endtask

   task automatic test_reset_mid();
      send_frame(16'h830B, 16, 250, 80, 40);
      send_frame(16'hFFFF, 8, 250, 80, 40);
      dshotPin = 1'b1;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (outputSpeed !== 8'd0) begin n_err++; $display("FAIL midrst_speed: got %0d expected 0", outputSpeed); end
      n_cmp++; if (throttle !== 11'd0) begin n_err++; $display("FAIL midrst_throttle: got %0d expected 0", throttle); end
      n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL midrst_to: got %b expected 0", timed_out); end
      dshotPin = 1'b0;
      rst_n    = 1'b1;
      repeat (50) @(negedge clk);
      mark();
      send_frame(16'hFFFF, 16, 0, 80, 40);
      n_cmp++; if (n_fv - pfv !== 0) begin n_err++; $display("FAIL midrst_nogap_fv: got %0d expected 0", n_fv - pfv); end
      mark();
      send_frame(16'hFFFF, 16, 250, 80, 40);
      n_cmp++; if (n_fv - pfv !== 1) begin n_err++; $display("FAIL midrst_next_fv: got %0d expected 1", n_fv - pfv); end
      n_cmp++; if (throttle !== 11'd2047) begin n_err++; $display("FAIL midrst_next_throttle: got %0d expected 2047", throttle); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full_scale();
      test_crc();
      test_truncated();
      test_long_high();
      test_boundaries();
      test_timeout();
      test_reset_mid();
      n_cmp++; if (n_overlap !== 0) begin n_err++; $display("FAIL pulse_overlap: got %0d expected 0", n_overlap); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
